// File: rtl/pkt_steer_avlstrm.sv
// pkt_steer_avlstrm
//   Packet-atomic N-way steering stage for Avalon-ST packet streams. Each
//   input packet is paired with one destination token; the whole packet is
//   forwarded to out[dest], or discarded when dest >= NOUT. Per-channel
//   packet counters plus drop / orphan / sop-error counters feed the stats
//   packer.
// Ports
//   Clk, Rst                    clock, synchronous active-high reset
//   in_*                        Avalon-ST packet input (data/valid/ready/sop/eop/empty)
//   dest_data/valid/ready       destination token stream, one token per packet
//   out_*                       NOUT Avalon-ST outputs, data/sop/eop/empty shared
//   stats_pkt                   NOUT x 32-bit completed-packet counters
//   stats_drop/orphan/sop_err   32-bit event counters, wrap modulo 2^32
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | between packets; pops a token when a sop beat is waiting
// FWD     | packet beats pass through to channel sel
// DROP    | packet beats are accepted and discarded
module pkt_steer_avlstrm #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int NOUT    = 4,
    parameter int DEST_W  = 3
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [EMPTY_W-1:0]      in_empty,
    input  logic [DEST_W-1:0]       dest_data,
    input  logic                    dest_valid,
    output logic                    dest_ready,
    output logic [NOUT*DATA_W-1:0]  out_data,
    output logic [NOUT-1:0]         out_valid,
    input  logic [NOUT-1:0]         out_ready,
    output logic [NOUT-1:0]         out_sop,
    output logic [NOUT-1:0]         out_eop,
    output logic [NOUT*EMPTY_W-1:0] out_empty,
    output logic [NOUT*32-1:0]      stats_pkt,
    output logic [31:0]             stats_drop,
    output logic [31:0]             stats_orphan,
    output logic [31:0]             stats_sop_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;

    // One extra bit so NOUT == 2^DEST_W still compares correctly.
    localparam logic [DEST_W:0] NOUT_W = (DEST_W+1)'(NOUT);

    state_e                 state_q, state_d;
    logic [DEST_W-1:0]      sel_q, sel_d;
    logic                   first_q, first_d;
    logic [NOUT-1:0][31:0]  pkt_cnt_q, pkt_cnt_d;
    logic [31:0]            drop_cnt_q, drop_cnt_d;
    logic [31:0]            orphan_cnt_q, orphan_cnt_d;
    logic [31:0]            sop_err_cnt_q, sop_err_cnt_d;
    logic                   sel_ready;
    logic                   accept;

    // Shared data path: every channel carries the input beat.
    assign out_data  = {NOUT{in_data}};
    assign out_sop   = {NOUT{in_sop}};
    assign out_eop   = {NOUT{in_eop}};
    assign out_empty = {NOUT{in_empty}};

    assign stats_pkt     = pkt_cnt_q;
    assign stats_drop    = drop_cnt_q;
    assign stats_orphan  = orphan_cnt_q;
    assign stats_sop_err = sop_err_cnt_q;

    assign accept = in_valid & in_ready;

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NOUT; i++) begin
            if (sel_q == DEST_W'(i)) sel_ready = out_ready[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            first_q       <= 1'b0;
            pkt_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            orphan_cnt_q  <= '0;
            sop_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            first_q       <= first_d;
            pkt_cnt_q     <= pkt_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            orphan_cnt_q  <= orphan_cnt_d;
            sop_err_cnt_q <= sop_err_cnt_d;
        end
    end

    // first_q marks the packet's own sop beat, which is not a sop error.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        first_d       = first_q;
        pkt_cnt_d     = pkt_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        orphan_cnt_d  = orphan_cnt_q;
        sop_err_cnt_d = sop_err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !in_sop) begin
                    orphan_cnt_d = orphan_cnt_q + 32'd1;
                end else if (in_valid && in_sop && dest_valid) begin
                    sel_d   = dest_data;
                    first_d = 1'b1;
                    state_d = ({1'b0, dest_data} < NOUT_W) ? ST_FWD : ST_DROP;
                end
            end
            ST_FWD: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (in_sop && !first_q) sop_err_cnt_d = sop_err_cnt_q + 32'd1;
                    if (in_eop) begin
                        state_d = ST_IDLE;
                        for (int i = 0; i < NOUT; i++) begin
                            if (sel_q == DEST_W'(i)) pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (in_eop) begin
                        state_d    = ST_IDLE;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshakes are held low while Rst is asserted.
    always_comb begin
        in_ready   = 1'b0;
        dest_ready = 1'b0;
        out_valid  = '0;
        if (!Rst) begin
            case (state_q)
                ST_IDLE: begin
                    in_ready   = in_valid & ~in_sop;
                    dest_ready = in_valid & in_sop & dest_valid;
                end
                ST_FWD: begin
                    in_ready = sel_ready;
                    for (int i = 0; i < NOUT; i++) begin
                        out_valid[i] = in_valid && (sel_q == DEST_W'(i));
                    end
                end
                ST_DROP: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_steer_avlstrm.sv
module tb_pkt_steer_avlstrm;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int NOUT    = 4;
    localparam int DEST_W  = 3;

    typedef struct packed {
        logic [DEST_W-1:0]  ch;
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    logic                    Clk;
    logic                    Rst;
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic [EMPTY_W-1:0]      in_empty;
    logic [DEST_W-1:0]       dest_data;
    logic                    dest_valid;
    logic                    dest_ready;
    logic [NOUT*DATA_W-1:0]  out_data;
    logic [NOUT-1:0]         out_valid;
    logic [NOUT-1:0]         out_ready;
    logic [NOUT-1:0]         out_sop;
    logic [NOUT-1:0]         out_eop;
    logic [NOUT*EMPTY_W-1:0] out_empty;
    logic [NOUT*32-1:0]      stats_pkt;
    logic [31:0]             stats_drop;
    logic [31:0]             stats_orphan;
    logic [31:0]             stats_sop_err;

    pkt_steer_avlstrm #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .NOUT(NOUT), .DEST_W(DEST_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .dest_data(dest_data), .dest_valid(dest_valid), .dest_ready(dest_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .stats_pkt(stats_pkt), .stats_drop(stats_drop),
        .stats_orphan(stats_orphan), .stats_sop_err(stats_sop_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: expected beats in delivery order plus expected counters.
    beat_t       exp_q[$];
    int          acc_cyc[$];
    logic [31:0] m_pkt[NOUT];
    logic [31:0] m_drop, m_orphan, m_sop_err;

    int bp_mode     = 0;
    int bp_lo_start = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        out_ready = '1;
        forever begin
            @(posedge Clk);
            #1;
            case (bp_mode)
                0: out_ready = '1;
                1: out_ready = NOUT'($urandom);
                default: begin
                    out_ready    = '1;
                    out_ready[0] = 1'b0;
                    out_ready[1] = !(cyc >= bp_lo_start && cyc < bp_lo_start + 3);
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NOUT; i++) m_pkt[i] = 32'd0;
        m_drop    = 32'd0;
        m_orphan  = 32'd0;
        m_sop_err = 32'd0;
    endtask

    task automatic check_stats(input string tag);
        for (int i = 0; i < NOUT; i++)
            chk($sformatf("%s_pkt%0d", tag, i), stats_pkt[i*32 +: 32], m_pkt[i]);
        chk({tag, "_drop"},    stats_drop,    m_drop);
        chk({tag, "_orphan"},  stats_orphan,  m_orphan);
        chk({tag, "_sop_err"}, stats_sop_err, m_sop_err);
    endtask

    // Monitor / scoreboard: pops one expected beat per accepted output beat.
    int    mon_nv;
    int    mon_ch;
    beat_t mon_got;
    beat_t mon_exp;
    always @(negedge Clk) begin
        if (Rst) begin
            checks++;
            if (out_valid !== '0 || in_ready !== 1'b0 || dest_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: out_valid=%b in_ready=%b dest_ready=%b, expected all 0",
                         out_valid, in_ready, dest_ready);
            end
        end else begin
            mon_nv = 0;
            mon_ch = 0;
            for (int i = 0; i < NOUT; i++) begin
                if (out_valid[i]) begin
                    mon_nv++;
                    mon_ch = i;
                end
            end
            if (mon_nv > 1) begin
                checks++;
                errors++;
                $display("FAIL one_hot_valid: out_valid=%b, expected at most one bit", out_valid);
            end else if (mon_nv == 1) begin
                checks++;
                if (in_ready !== out_ready[mon_ch]) begin
                    errors++;
                    $display("FAIL ready_track: in_ready=%b, expected out_ready[%0d]=%b",
                             in_ready, mon_ch, out_ready[mon_ch]);
                end
                if (out_ready[mon_ch]) begin
                    mon_got.ch    = DEST_W'(mon_ch);
                    mon_got.data  = out_data[mon_ch*DATA_W +: DATA_W];
                    mon_got.sop   = out_sop[mon_ch];
                    mon_got.eop   = out_eop[mon_ch];
                    mon_got.empty = out_empty[mon_ch*EMPTY_W +: EMPTY_W];
                    acc_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: ch=%0d data=%0h, expected no beat",
                                 mon_ch, mon_got.data[31:0]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL beat: got ch=%0d d=%0h sop=%b eop=%b e=%0d, expected ch=%0d d=%0h sop=%b eop=%b e=%0d",
                                     mon_got.ch, mon_got.data[31:0], mon_got.sop, mon_got.eop, mon_got.empty,
                                     mon_exp.ch, mon_exp.data[31:0], mon_exp.sop, mon_exp.eop, mon_exp.empty);
                        end
                    end
                end
            end
        end
    end

    // Sends one packet. abort_at > 0 stops after that many beats (no eop sent).
    task automatic send_pkt(input int dest, input int nbeats, input int err_idx,
                            input int max_gap, input int tok_delay, input int abort_at,
                            output int ncyc);
        beat_t bt;
        int    k, gap, nb;
        bit    acc, pop, popped;
        ncyc   = 0;
        popped = 0;
        nb     = (abort_at > 0) ? abort_at : nbeats;
        for (int b = 0; b < nb; b++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_sop   = 1'($urandom);
                in_eop   = 1'($urandom);
                @(posedge Clk);
                #1;
                ncyc++;
            end
            bt.ch    = DEST_W'(dest);
            bt.data  = {16{$urandom}};
            bt.sop   = (b == 0) || (b == err_idx);
            bt.eop   = (b == nbeats - 1);
            bt.empty = bt.eop ? EMPTY_W'($urandom_range(0, 63)) : '0;
            if (dest < NOUT) exp_q.push_back(bt);
            in_valid  = 1'b1;
            in_data   = bt.data;
            in_sop    = bt.sop;
            in_eop    = bt.eop;
            in_empty  = bt.empty;
            dest_data = DEST_W'(dest);
            k = 0;
            forever begin
                dest_valid = (b == 0) && (k >= tok_delay) && !popped;
                @(negedge Clk);
                acc = in_ready;
                pop = dest_valid && dest_ready;
                @(posedge Clk);
                #1;
                ncyc++;
                k++;
                if (pop) popped = 1;
                if (acc) break;
                if (k >= 300) begin
                    errors++;
                    checks++;
                    $display("FAIL beat_timeout: beat %0d of packet to %0d not accepted in 300 cycles", b, dest);
                    break;
                end
            end
            dest_valid = 1'b0;
            in_valid   = 1'b0;
            if (b == 0) chk("token_popped", 32'(popped), 32'd1);
        end
        in_sop = 1'b0;
        in_eop = 1'b0;
        if (abort_at == 0) begin
            if (dest < NOUT) begin
                m_pkt[dest] = m_pkt[dest] + 32'd1;
                if (err_idx > 0 && err_idx < nbeats) m_sop_err = m_sop_err + 32'd1;
            end else begin
                m_drop = m_drop + 32'd1;
            end
        end
    endtask

    task automatic send_orphan();
        int k;
        bit acc;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'($urandom);
        in_data  = {16{$urandom}};
        k = 0;
        forever begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            #1;
            k++;
            if (acc) break;
            if (k >= 50) begin
                errors++;
                checks++;
                $display("FAIL orphan_timeout: orphan beat not accepted in 50 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        m_orphan = m_orphan + 32'd1;
    endtask

    task automatic pulse_rst();
        Rst        = 1'b1;
        in_valid   = 1'b0;
        dest_valid = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        Rst = 1'b0;
        model_clear();
    endtask

    int                 n;
    logic [NOUT*32-1:0] fv;

    initial begin
        Rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_empty   = '0;
        dest_data  = '0;
        dest_valid = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        check_stats("reset");
        Rst = 1'b0;

        // A token with no packet waiting is never popped.
        dest_valid = 1'b1;
        dest_data  = 3'd1;
        repeat (2) begin
            @(negedge Clk);
            chk("token_no_pkt", 32'(dest_ready), 32'd0);
            @(posedge Clk);
            #1;
        end
        dest_valid = 1'b0;

        // Basic steering: token 2, three beats, one bubble cycle.
        bp_mode = 0;
        send_pkt(2, 3, -1, 0, 0, 0, n);
        chk("basic_cycles", 32'(n), 32'd4);
        check_stats("basic");

        // Drop token: four beats accepted in four cycles after the pop.
        send_pkt(5, 4, -1, 0, 0, 0, n);
        chk("drop_cycles", 32'(n), 32'd5);
        check_stats("drop");

        // Back-pressure: out_ready[1] low for 3 cycles mid-packet, out_ready[0] low.
        bp_lo_start = cyc + 4;
        bp_mode     = 2;
        @(posedge Clk);
        #1;
        send_pkt(1, 5, -1, 0, 0, 0, n);
        chk("bp_cycles", 32'(n), 32'd9);
        check_stats("bp");
        bp_mode = 0;
        @(posedge Clk);
        #1;

        // Back-to-back single-beat packets, one beat every two cycles.
        acc_cyc.delete();
        for (int d = 0; d < NOUT; d++) send_pkt(d, 1, -1, 0, 0, 0, n);
        chk("b2b_count", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
        end
        check_stats("b2b");

        // Orphan beat and extra sop inside a packet.
        send_orphan();
        send_pkt(0, 4, 2, 0, 1, 0, n);
        check_stats("orph_soperr");

        // Reset mid-packet; the tail beats become orphans.
        send_pkt(3, 4, -1, 0, 0, 2, n);
        pulse_rst();
        check_stats("rst_mid");
        send_orphan();
        send_orphan();
        check_stats("rst_tail");

        // Counter wrap on channel 0.
        m_pkt[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < NOUT; i++) fv[i*32 +: 32] = m_pkt[i];
        force dut.pkt_cnt_q = fv;
        @(posedge Clk);
        #1;
        release dut.pkt_cnt_q;
        chk("wrap_preload", stats_pkt[31:0], 32'hFFFF_FFFF);
        send_pkt(0, 2, -1, 0, 0, 0, n);
        chk("wrap_result", stats_pkt[31:0], 32'd0);
        check_stats("wrap");

        // Randomized traffic.
        for (int p = 0; p < 40; p++) begin
            int d, len, eidx;
            bp_mode = $urandom_range(0, 1);
            d       = $urandom_range(0, 7);
            len     = $urandom_range(1, 5);
            eidx    = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
            if ($urandom_range(0, 5) == 0) send_orphan();
            send_pkt(d, len, eidx, 2, $urandom_range(0, 3), 0, n);
        end
        bp_mode = 0;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        check_stats("random");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
